noc_link_credit_buffer: RTL and testbench

Elastic, credit-based buffer stage placed on a router-to-router link, directly downstream of a router output port (data_out/dest_out/is_tail_out/send_out, credit_in) and feeding the neighbour router's input port.
Decouples the two routers so long inter-router wires can be registered without stalling the network.
Holds up to BUFFER_DEPTH flits and returns one credit upstream per flit drained.
Tracks the downstream router's input-buffer credits and forwards only when a credit is available.

---
 rtl/noc_link_pkg.sv | 27 ++
 rtl/noc_link_flit_fifo.sv | 90 +++++++++
 rtl/noc_link_credit_buffer.sv | 127 ++++++++++++
 tb/tb_noc_link_credit_buffer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_link_pkg.sv
// Shared definitions for the NoC link credit buffer.
//
// flit_t is the router-native flit layout {is_tail, dest, data}. The link FIFO
// stores entries packed in this same order, so a flit can be moved between the
// router and the link stage without reshuffling bits.
package noc_link_pkg;

    localparam int unsigned NOC_FLIT_WIDTH = 64;
    localparam int unsigned NOC_DEST_WIDTH = 6;

    typedef struct packed {
        logic                      is_tail;
        logic [NOC_DEST_WIDTH-1:0] dest;
        logic [NOC_FLIT_WIDTH-1:0] data;
    } flit_t;

    // Width of a counter that must represent 0..credits inclusive.
    function automatic int unsigned credit_cnt_width(input int unsigned credits);
        return $clog2(credits + 1);
    endfunction

    // Pointer width for a FIFO of the given depth; a depth of 1 still needs one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/noc_link_flit_fifo.sv
// Synchronous flit FIFO for the link credit buffer.
//
// Ports:
//   clk_noc, rst_noc  clock, asynchronous active-high reset (clears pointers/occupancy)
//   push, wdata       write request and entry; ignored when full unless popping
//   pop, rdata        read request; rdata is the current head (valid when !empty)
//   full, empty       status flags
//   occupancy         number of stored entries (0..DEPTH)
//
// A push while full is accepted only if a pop happens in the same cycle; the
// head is read before the edge, so overwriting the freed slot is safe.
module noc_link_flit_fifo
    import noc_link_pkg::*;
#(
    parameter int unsigned WIDTH = 71,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk_noc,
    input  logic                           rst_noc,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

    localparam int unsigned PTR_WIDTH = ptr_width(DEPTH);
    localparam int unsigned OCC_WIDTH = $clog2(DEPTH + 1);
    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);
    localparam logic [OCC_WIDTH-1:0] OCC_FULL = OCC_WIDTH'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_WIDTH-1:0] occ_q, occ_d;
    logic                 push_ok;
    logic                 pop_ok;

    // Explicit compare-and-reset so non-power-of-two depths wrap correctly.
    function automatic logic [PTR_WIDTH-1:0] inc_ptr(input logic [PTR_WIDTH-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign full      = (occ_q == OCC_FULL);
    assign empty     = (occ_q == '0);
    assign occupancy = occ_q;
    assign rdata     = mem[rd_ptr_q];

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_ok) begin
            wr_ptr_d = inc_ptr(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = inc_ptr(rd_ptr_q);
        end
        if (push_ok && !pop_ok) begin
            occ_d = occ_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage carries no reset; stale contents are never visible past the pointers.
    always_ff @(posedge clk_noc) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/noc_link_credit_buffer.sv
// Elastic credit-based buffer stage on a router-to-router link.
//
// Ports:
//   clk_noc, rst_noc              NoC clock, asynchronous active-high reset
//   data_in/dest_in/is_tail_in    flit from the upstream router output port
//   send_in                       flit valid (one cycle per flit)
//   credit_out                    pulse: one local entry freed (returned upstream)
//   data_out/dest_out/is_tail_out registered flit to the downstream router
//   send_out                      pulse: one flit sent downstream
//   credit_in                     pulse: one downstream input entry freed
//   occupancy                     local entries in use
//   overflow_err                  sticky: flit dropped because the buffer was full
//   credit_err                    sticky: credit returned while the counter was saturated
//
// A flit is popped when the buffer is non-empty and the downstream credit
// counter is non-zero; a credit arriving in the same cycle is only counted at
// the edge, so it cannot enable that cycle's pop.
module noc_link_credit_buffer
    import noc_link_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH         = 64,
    parameter int unsigned DEST_WIDTH         = 6,
    parameter int unsigned BUFFER_DEPTH       = 4,
    parameter int unsigned DOWNSTREAM_CREDITS = 1
) (
    input  logic                                clk_noc,
    input  logic                                rst_noc,
    input  logic [FLIT_WIDTH-1:0]               data_in,
    input  logic [DEST_WIDTH-1:0]               dest_in,
    input  logic                                is_tail_in,
    input  logic                                send_in,
    output logic                                credit_out,
    output logic [FLIT_WIDTH-1:0]               data_out,
    output logic [DEST_WIDTH-1:0]               dest_out,
    output logic                                is_tail_out,
    output logic                                send_out,
    input  logic                                credit_in,
    output logic [$clog2(BUFFER_DEPTH+1)-1:0]   occupancy,
    output logic                                overflow_err,
    output logic                                credit_err
);

    localparam int unsigned ENTRY_WIDTH = FLIT_WIDTH + DEST_WIDTH + 1;
    localparam int unsigned CNT_WIDTH   = credit_cnt_width(DOWNSTREAM_CREDITS);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DOWNSTREAM_CREDITS);

    logic [ENTRY_WIDTH-1:0] head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic                   overflow_evt;
    logic                   credit_sat;
    logic [CNT_WIDTH-1:0]   credit_q, credit_d;

    noc_link_flit_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clk_noc   (clk_noc),
        .rst_noc   (rst_noc),
        .push      (send_in),
        .wdata     ({is_tail_in, dest_in, data_in}),
        .pop       (pop),
        .rdata     (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (occupancy)
    );

    assign pop          = !fifo_empty && (credit_q != '0);
    assign overflow_evt = send_in && fifo_full && !pop;

    // Credit counter: next = count - pop + credit_in, saturating at the reset value.
    always_comb begin
        credit_d   = credit_q;
        credit_sat = 1'b0;
        if (pop && !credit_in) begin
            credit_d = credit_q - 1'b1;
        end else if (!pop && credit_in) begin
            if (credit_q == CNT_MAX) begin
                credit_sat = 1'b1;
            end else begin
                credit_d = credit_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            credit_q <= CNT_MAX;
        end else begin
            credit_q <= credit_d;
        end
    end

    // Output stage: the popped head is registered; data holds when idle.
    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            send_out    <= 1'b0;
            credit_out  <= 1'b0;
            data_out    <= '0;
            dest_out    <= '0;
            is_tail_out <= 1'b0;
        end else begin
            send_out   <= pop;
            credit_out <= pop;
            if (pop) begin
                {is_tail_out, dest_out, data_out} <= head;
            end
        end
    end

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            overflow_err <= 1'b0;
            credit_err   <= 1'b0;
        end else begin
            if (overflow_evt) begin
                overflow_err <= 1'b1;
            end
            if (credit_sat) begin
                credit_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_link_credit_buffer.sv
// Bench for noc_link_credit_buffer. Two instances share clock and reset:
// dut_a with one downstream credit, dut_b with four.
module tb_noc_link_credit_buffer;

    logic clk_noc = 1'b0;
    logic rst_noc = 1'b1;
    always #5 clk_noc = ~clk_noc;

    logic [63:0] a_data_in, a_data_out, b_data_in, b_data_out;
    logic [5:0]  a_dest_in, a_dest_out, b_dest_in, b_dest_out;
    logic        a_tail_in, a_tail_out, b_tail_in, b_tail_out;
    logic        a_send_in, a_send_out, b_send_in, b_send_out;
    logic        a_credit_in, a_credit_out, b_credit_in, b_credit_out;
    logic [2:0]  a_occ, b_occ;
    logic        a_ovf, a_cerr, b_ovf, b_cerr;

    noc_link_credit_buffer #(
        .FLIT_WIDTH (64), .DEST_WIDTH (6), .BUFFER_DEPTH (4), .DOWNSTREAM_CREDITS (1)
    ) dut_a (
        .clk_noc (clk_noc), .rst_noc (rst_noc),
        .data_in (a_data_in), .dest_in (a_dest_in), .is_tail_in (a_tail_in),
        .send_in (a_send_in), .credit_out (a_credit_out),
        .data_out (a_data_out), .dest_out (a_dest_out), .is_tail_out (a_tail_out),
        .send_out (a_send_out), .credit_in (a_credit_in), .occupancy (a_occ),
        .overflow_err (a_ovf), .credit_err (a_cerr)
    );

    noc_link_credit_buffer #(
        .FLIT_WIDTH (64), .DEST_WIDTH (6), .BUFFER_DEPTH (4), .DOWNSTREAM_CREDITS (4)
    ) dut_b (
        .clk_noc (clk_noc), .rst_noc (rst_noc),
        .data_in (b_data_in), .dest_in (b_dest_in), .is_tail_in (b_tail_in),
        .send_in (b_send_in), .credit_out (b_credit_out),
        .data_out (b_data_out), .dest_out (b_dest_out), .is_tail_out (b_tail_out),
        .send_out (b_send_out), .credit_in (b_credit_in), .occupancy (b_occ),
        .overflow_err (b_ovf), .credit_err (b_cerr)
    );

    int checks = 0;
    int passed = 0;
    logic [63:0] a_got[$];
    logic [63:0] b_got[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // One clock: inputs already driven; sample #1 after the edge and log sent flits.
    task automatic step();
        @(posedge clk_noc);
        #1;
        if (a_send_out) a_got.push_back(a_data_out);
        if (b_send_out) b_got.push_back(b_data_out);
    endtask

    task automatic drive_b(input logic send, input logic [63:0] data, input logic credit);
        b_send_in   = send;
        b_data_in   = data;
        b_dest_in   = data[5:0];
        b_tail_in   = data[0];
        b_credit_in = credit;
        step();
    endtask

    task automatic drive_a(input logic send, input logic [63:0] data, input logic credit);
        a_send_in   = send;
        a_data_in   = data;
        a_dest_in   = data[5:0];
        a_tail_in   = data[0];
        a_credit_in = credit;
        step();
    endtask

    // Inputs apply before an edge; expectations are the outputs right after it.
    typedef struct {
        logic        send;
        logic [63:0] data;
        logic [5:0]  dest;
        logic        tail;
        logic        credit;
        logic        exp_send;
        logic [63:0] exp_data;
        logic [5:0]  exp_dest;
        logic        exp_tail;
        logic [2:0]  exp_occ;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic s, input logic [63:0] d, input logic [5:0] ds,
                                input logic t, input logic c, input logic es,
                                input logic [63:0] ed, input logic [5:0] eds,
                                input logic et, input logic [2:0] eo);
        vec_t v;
        v.send = s; v.data = d; v.dest = ds; v.tail = t; v.credit = c;
        v.exp_send = es; v.exp_data = ed; v.exp_dest = eds; v.exp_tail = et; v.exp_occ = eo;
        return v;
    endfunction

    logic [63:0] v;

    initial begin
        // Single flit, then a 3-flit stream through dut_a (one downstream credit).
        vecs[0]  = mk(0, 64'h0,  6'h00, 0, 0,  0, 64'h0,  6'h00, 0, 3'd0);
        vecs[1]  = mk(1, 64'hA5, 6'h09, 1, 0,  0, 64'h0,  6'h00, 0, 3'd1);
        vecs[2]  = mk(0, 64'h0,  6'h00, 0, 0,  1, 64'hA5, 6'h09, 1, 3'd0);
        vecs[3]  = mk(0, 64'h0,  6'h00, 0, 0,  0, 64'hA5, 6'h09, 1, 3'd0);
        vecs[4]  = mk(0, 64'h0,  6'h00, 0, 1,  0, 64'hA5, 6'h09, 1, 3'd0);
        vecs[5]  = mk(1, 64'h11, 6'h01, 0, 0,  0, 64'hA5, 6'h09, 1, 3'd1);
        vecs[6]  = mk(1, 64'h22, 6'h02, 0, 0,  1, 64'h11, 6'h01, 0, 3'd1);
        vecs[7]  = mk(1, 64'h33, 6'h03, 1, 0,  0, 64'h11, 6'h01, 0, 3'd2);
        vecs[8]  = mk(0, 64'h0,  6'h00, 0, 0,  0, 64'h11, 6'h01, 0, 3'd2);
        vecs[9]  = mk(0, 64'h0,  6'h00, 0, 0,  0, 64'h11, 6'h01, 0, 3'd2);
        vecs[10] = mk(0, 64'h0,  6'h00, 0, 1,  0, 64'h11, 6'h01, 0, 3'd2);
        vecs[11] = mk(0, 64'h0,  6'h00, 0, 0,  1, 64'h22, 6'h02, 0, 3'd1);
        vecs[12] = mk(0, 64'h0,  6'h00, 0, 1,  0, 64'h22, 6'h02, 0, 3'd1);
        vecs[13] = mk(0, 64'h0,  6'h00, 0, 0,  1, 64'h33, 6'h03, 1, 3'd0);
        vecs[14] = mk(0, 64'h0,  6'h00, 0, 1,  0, 64'h33, 6'h03, 1, 3'd0);

        {a_send_in, a_data_in, a_dest_in, a_tail_in, a_credit_in} = '0;
        {b_send_in, b_data_in, b_dest_in, b_tail_in, b_credit_in} = '0;
        repeat (3) @(posedge clk_noc);
        #1;
        check("reset send_out", a_send_out, 0);
        check("reset credit_out", a_credit_out, 0);
        check("reset data_out", a_data_out, 0);
        check("reset occupancy", b_occ, 0);
        check("reset errors", {a_ovf, a_cerr, b_ovf, b_cerr}, 0);
        rst_noc = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            a_send_in   = vecs[i].send;
            a_data_in   = vecs[i].data;
            a_dest_in   = vecs[i].dest;
            a_tail_in   = vecs[i].tail;
            a_credit_in = vecs[i].credit;
            step();
            check($sformatf("vec%0d send_out", i), a_send_out, vecs[i].exp_send);
            check($sformatf("vec%0d credit_out", i), a_credit_out, vecs[i].exp_send);
            check($sformatf("vec%0d data_out", i), a_data_out, vecs[i].exp_data);
            check($sformatf("vec%0d dest_out", i), a_dest_out, vecs[i].exp_dest);
            check($sformatf("vec%0d is_tail_out", i), a_tail_out, vecs[i].exp_tail);
            check($sformatf("vec%0d occupancy", i), a_occ, vecs[i].exp_occ);
        end
        a_credit_in = 1'b0;
        check("a errors clean", {a_ovf, a_cerr}, 0);

        // dut_b: 8 back-to-back flits, credit returned alongside every pop.
        for (int i = 0; i < 10; i++) begin
            drive_b(i < 8, 64'h100 + 64'(i), (i >= 1) && (i <= 8));
            check($sformatf("stream%0d send_out", i), b_send_out, (i >= 1) && (i <= 8));
            check($sformatf("stream%0d credit_out", i), b_credit_out, (i >= 1) && (i <= 8));
            if ((i >= 1) && (i <= 8))
                check($sformatf("stream%0d data_out", i), b_data_out, 64'h100 + 64'(i - 1));
            check($sformatf("stream%0d occupancy", i), b_occ, (i <= 7) ? 1 : 0);
        end
        check("stream credit_err", b_cerr, 0);

        // Credit returned while counter is saturated and buffer empty.
        drive_b(0, 64'h0, 1);
        check("saturate credit_err", b_cerr, 1);
        check("saturate send_out", b_send_out, 0);
        drive_b(0, 64'h0, 0);

        // Counter must still be 4: of 5 flits only 4 leave without credits.
        b_got.delete();
        for (int i = 0; i < 8; i++) drive_b(i < 5, 64'h200 + 64'(i), 0);
        check("credits held count", b_got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            v = (i < b_got.size()) ? b_got[i] : '1;
            check($sformatf("credits held flit%0d", i), v, 64'h200 + 64'(i));
        end
        check("credits held occupancy", b_occ, 1);

        // Fill to 4 entries with zero credits, then overflow.
        for (int i = 5; i < 8; i++) drive_b(1, 64'h200 + 64'(i), 0);
        check("fill occupancy", b_occ, 4);
        check("fill overflow_err", b_ovf, 0);
        drive_b(1, 64'h2FF, 0);
        check("overflow overflow_err", b_ovf, 1);
        check("overflow occupancy", b_occ, 4);

        b_got.delete();
        for (int k = 0; k < 4; k++) begin
            drive_b(0, 64'h0, 1);
            drive_b(0, 64'h0, 0);
            drive_b(0, 64'h0, 0);
        end
        for (int k = 0; k < 4; k++) drive_b(0, 64'h0, 0);
        check("drain count", b_got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            v = (i < b_got.size()) ? b_got[i] : '1;
            check($sformatf("drain flit%0d", i), v, 64'h204 + 64'(i));
        end
        check("drain occupancy", b_occ, 0);

        // Reset with 3 flits buffered in dut_a (its only credit is spent).
        for (int i = 0; i < 4; i++) drive_a(1, 64'h301 + 64'(i), 0);
        a_send_in = 1'b0;
        check("pre-reset occupancy", a_occ, 3);
        check("pre-reset data_out", a_data_out, 64'h301);
        #2 rst_noc = 1'b1;
        #1;
        check("async occupancy", a_occ, 0);
        check("async data_out", a_data_out, 0);
        check("async dest/tail", {a_dest_out, a_tail_out}, 0);
        check("async send/credit", {a_send_out, a_credit_out}, 0);
        check("async sticky errors", {b_ovf, b_cerr}, 0);
        @(posedge clk_noc);
        #1 rst_noc = 1'b0;

        a_got.delete();
        for (int i = 0; i < 4; i++) drive_a(0, 64'h0, 0);
        check("post-reset no send", a_got.size(), 0);
        check("post-reset occupancy", a_occ, 0);
        drive_a(1, 64'h3AA, 0);
        for (int i = 0; i < 3; i++) drive_a(0, 64'h0, 0);
        check("post-reset credit restored", a_got.size(), 1);
        v = (a_got.size() > 0) ? a_got[0] : '1;
        check("post-reset flit", v, 64'h3AA);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
